// File: rtl/mem_stage_sram_ctrl_if.sv
// Bundle of the MEM-stage request/response signals and the external 16-bit SRAM pins.
// slave  : the controller's view.
// master : the view of the pipeline plus the SRAM device.
interface mem_stage_sram_ctrl_if;
    logic        rd_en;
    logic        wr_en;
    logic [31:0] address;
    logic [31:0] write_data;
    logic [31:0] read_data;
    logic        ready;
    logic [17:0] SRAM_ADDR;
    logic [15:0] SRAM_DQ_out;
    logic        SRAM_DQ_oe;
    logic [15:0] SRAM_DQ_in;
    logic        SRAM_WE_N;
    logic        SRAM_OE_N;

    modport slave (
        input  rd_en, wr_en, address, write_data, SRAM_DQ_in,
        output read_data, ready, SRAM_ADDR, SRAM_DQ_out, SRAM_DQ_oe, SRAM_WE_N, SRAM_OE_N
    );

    modport master (
        output rd_en, wr_en, address, write_data, SRAM_DQ_in,
        input  read_data, ready, SRAM_ADDR, SRAM_DQ_out, SRAM_DQ_oe, SRAM_WE_N, SRAM_OE_N
    );
endinterface

// File: rtl/mem_stage_sram_ctrl.sv
// MEM-stage controller: turns one 32-bit load/store into two halfword SRAM phases
// (low half first), each held for WAIT_CYCLES+1 cycles. ready drops while an access
// is in flight so the pipeline freezes until the DONE cycle.
module mem_stage_sram_ctrl #(
    parameter int unsigned WAIT_CYCLES = 1,
    parameter logic [31:0] ADDR_BASE   = 32'd1024
) (
    input  logic                    clk,
    input  logic                    rst,
    mem_stage_sram_ctrl_if.slave    bus
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOW  = 2'd1,
        HIGH = 2'd2,
        DONE = 2'd3
    } state_t;

    localparam logic [2:0] WAIT_LAST = 3'(WAIT_CYCLES);

    state_t      state_q, state_d;
    logic [2:0]  cnt_q, cnt_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [31:0] rdata_q, rdata_d;
    logic        wr_q, wr_d;          // latched op: 1 = store, 0 = load

    logic        req;
    logic        phase_end;
    logic [16:0] word;

    assign req       = bus.rd_en | bus.wr_en;
    assign phase_end = (cnt_q == WAIT_LAST);
    // Word index wraps modulo 2^17; out-of-range addresses are not trapped.
    assign word      = 17'((addr_q - ADDR_BASE) >> 2);

    // State and datapath registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            wr_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            wr_q    <= wr_d;
        end
    end

    // Next-state: latch the request in IDLE, count wait states per phase,
    // capture read halves on the last cycle of each phase.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        wr_d    = wr_q;
        case (state_q)
            IDLE: begin
                if (req) begin
                    addr_d  = bus.address;
                    wdata_d = bus.write_data;
                    wr_d    = bus.wr_en;      // store wins when both are requested
                    cnt_d   = '0;
                    state_d = LOW;
                end
            end
            LOW: begin
                if (phase_end) begin
                    cnt_d   = '0;
                    state_d = HIGH;
                    if (!wr_q) rdata_d[15:0] = bus.SRAM_DQ_in;
                end else begin
                    cnt_d = cnt_q + 3'd1;
                end
            end
            HIGH: begin
                if (phase_end) begin
                    cnt_d   = '0;
                    state_d = DONE;
                    if (!wr_q) rdata_d[31:16] = bus.SRAM_DQ_in;
                end else begin
                    cnt_d = cnt_q + 3'd1;
                end
            end
            // A request still held during DONE is the one just served; never restart on it.
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // SRAM pin drive, decoded from the current phase and the latched op.
    always_comb begin
        bus.SRAM_ADDR   = '0;
        bus.SRAM_DQ_out = '0;
        bus.SRAM_DQ_oe  = 1'b0;
        bus.SRAM_WE_N   = 1'b1;
        bus.SRAM_OE_N   = 1'b1;
        if (state_q == LOW || state_q == HIGH) begin
            bus.SRAM_ADDR = {word, (state_q == HIGH)};
            if (wr_q) begin
                bus.SRAM_WE_N   = 1'b0;
                bus.SRAM_DQ_oe  = 1'b1;
                bus.SRAM_DQ_out = (state_q == HIGH) ? wdata_q[31:16] : wdata_q[15:0];
            end else begin
                bus.SRAM_OE_N = 1'b0;
            end
        end
    end

    assign bus.ready     = ((state_q == IDLE) && !req) || (state_q == DONE);
    assign bus.read_data = rdata_q;

endmodule

// File: tb/tb_mem_stage_sram_ctrl.sv
// Bench for mem_stage_sram_ctrl: two instances (WAIT_CYCLES=1 and 0), each attached
// to its own behavioural SRAM. Directed table vectors, a reset-mid-access sequence,
// and random loads/stores checked against a word-level reference memory.
module tb_mem_stage_sram_ctrl;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    // Shared request drive; sel picks which instance sees it (1: WAIT=1, 0: WAIT=0).
    logic        sel = 1'b1;
    logic        rd_en = 1'b0, wr_en = 1'b0;
    logic [31:0] address = '0, write_data = '0;

    mem_stage_sram_ctrl_if if1 ();
    mem_stage_sram_ctrl_if if0 ();

    assign if1.rd_en      = sel ? rd_en : 1'b0;
    assign if1.wr_en      = sel ? wr_en : 1'b0;
    assign if1.address    = address;
    assign if1.write_data = write_data;
    assign if0.rd_en      = sel ? 1'b0 : rd_en;
    assign if0.wr_en      = sel ? 1'b0 : wr_en;
    assign if0.address    = address;
    assign if0.write_data = write_data;

    mem_stage_sram_ctrl #(.WAIT_CYCLES(1), .ADDR_BASE(32'd1024)) dut1 (.clk(clk), .rst(rst), .bus(if1));
    mem_stage_sram_ctrl #(.WAIT_CYCLES(0), .ADDR_BASE(32'd1024)) dut0 (.clk(clk), .rst(rst), .bus(if0));

    // Behavioural SRAMs (one per instance).
    logic [15:0] mem1 [0:262143];
    logic [15:0] mem0 [0:262143];
    always @(posedge clk) if (!if1.SRAM_WE_N) mem1[if1.SRAM_ADDR] <= if1.SRAM_DQ_out;
    always @(posedge clk) if (!if0.SRAM_WE_N) mem0[if0.SRAM_ADDR] <= if0.SRAM_DQ_out;
    always_comb if1.SRAM_DQ_in = mem1[if1.SRAM_ADDR];
    always_comb if0.SRAM_DQ_in = mem0[if0.SRAM_ADDR];

    // Selected-instance observation.
    logic        m_ready, m_we_n, m_oe_n, m_oe;
    logic [31:0] m_rdata;
    logic [17:0] m_addr;
    logic [15:0] m_dq;
    assign m_ready = sel ? if1.ready       : if0.ready;
    assign m_rdata = sel ? if1.read_data   : if0.read_data;
    assign m_addr  = sel ? if1.SRAM_ADDR   : if0.SRAM_ADDR;
    assign m_we_n  = sel ? if1.SRAM_WE_N   : if0.SRAM_WE_N;
    assign m_oe_n  = sel ? if1.SRAM_OE_N   : if0.SRAM_OE_N;
    assign m_oe    = sel ? if1.SRAM_DQ_oe  : if0.SRAM_DQ_oe;
    assign m_dq    = sel ? if1.SRAM_DQ_out : if0.SRAM_DQ_out;

    int checks = 0;
    int failures = 0;
    int txn_no = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s (txn %0d) actual=0x%0h required=0x%0h", nm, txn_no, act, exp);
        end
    endtask

    // One access on instance s. Checks ready low in the request cycle, the pin
    // pattern of every phase cycle, then ready high (and optionally read_data) in DONE.
    // Returns at the DONE mid-cycle with the request still applied.
    task automatic run_txn(input bit s, input logic rd, input logic wr,
                           input logic [31:0] a, input logic [31:0] d,
                           input logic [17:0] ea, input logic [15:0] dlo, input logic [15:0] dhi,
                           input bit chk_rd, input logic [31:0] erd);
        int ph;
        logic [36:0] act, exp;
        ph = s ? 2 : 1;
        txn_no++;
        $display("txn %0d inst=W%0d rd=%0d wr=%0d addr=0x%08h wdata=0x%08h", txn_no, s ? 1 : 0, rd, wr, a, d);
        @(posedge clk); #1;
        sel = s; rd_en = rd; wr_en = wr; address = a; write_data = d;
        @(negedge clk);
        chk("ready_req", {63'd0, m_ready}, 64'd0);
        for (int c = 0; c < 2 * ph; c++) begin
            @(posedge clk); #1;
            // Garbage on the inputs after latching must be ignored.
            address = $urandom; write_data = $urandom;
            @(negedge clk);
            chk("ready_busy", {63'd0, m_ready}, 64'd0);
            if (wr) begin
                act = {m_addr, m_we_n, m_oe_n, m_oe, m_dq};
                exp = {(c < ph) ? ea : (ea | 18'd1), 1'b0, 1'b1, 1'b1, (c < ph) ? dlo : dhi};
                chk("wr_phase", {27'd0, act}, {27'd0, exp});
            end else begin
                act = {m_addr, m_we_n, m_oe_n, m_oe, 16'h0};
                exp = {(c < ph) ? ea : (ea | 18'd1), 1'b1, 1'b0, 1'b0, 16'h0};
                chk("rd_phase", {27'd0, act}, {27'd0, exp});
            end
        end
        @(posedge clk); #1;
        @(negedge clk);
        chk("ready_done", {63'd0, m_ready}, 64'd1);
        if (chk_rd) chk("read_data", {32'd0, m_rdata}, {32'd0, erd});
    endtask

    task automatic idle_cycle();
        @(posedge clk); #1;
        rd_en = 1'b0; wr_en = 1'b0;
        @(negedge clk);
        chk("idle_pins", {41'd0, m_ready, m_we_n, m_oe_n, m_oe, m_addr},
                         {41'd0, 1'b1, 1'b1, 1'b1, 1'b0, 18'd0});
    endtask

    typedef struct {
        bit          s;
        logic        rd, wr;
        logic [31:0] a, d;
        logic [17:0] ea;
        logic [15:0] dlo, dhi;
        bit          chk_rd;
        logic [31:0] erd;
        bit          hold;    // start the next vector straight after DONE
    } vec_t;

    vec_t vecs [7];

    // Word-level reference for random traffic.
    logic [31:0] ref_mem [2][256];
    bit          ref_ok  [2][256];
    logic [31:0] last_rd [2];

    initial begin
        vecs[0] = '{1'b1, 1'b0, 1'b1, 32'd1032, 32'hDEADBEEF, 18'd4, 16'hBEEF, 16'hDEAD, 1'b0, 32'h0, 1'b0};
        vecs[1] = '{1'b1, 1'b1, 1'b0, 32'd1032, 32'h0, 18'd4, 16'h0, 16'h0, 1'b1, 32'hDEADBEEF, 1'b1};
        vecs[2] = '{1'b1, 1'b0, 1'b1, 32'd1036, 32'h12345678, 18'd6, 16'h5678, 16'h1234, 1'b0, 32'h0, 1'b0};
        vecs[3] = '{1'b0, 1'b1, 1'b1, 32'd1024, 32'h0000AAAA, 18'd0, 16'hAAAA, 16'h0000, 1'b1, 32'h0, 1'b0};
        vecs[4] = '{1'b0, 1'b1, 1'b0, 32'd1024, 32'h0, 18'd0, 16'h0, 16'h0, 1'b1, 32'h0000AAAA, 1'b0};
        vecs[5] = '{1'b1, 1'b0, 1'b1, 32'd1020, 32'hCAFEF00D, 18'h3FFFE, 16'hF00D, 16'hCAFE, 1'b0, 32'h0, 1'b0};
        vecs[6] = '{1'b1, 1'b1, 1'b0, 32'd1020, 32'h0, 18'h3FFFE, 16'h0, 16'h0, 1'b1, 32'hCAFEF00D, 1'b0};

        // Reset held for two cycles with no request.
        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset_pins", {32'd0, m_ready, m_we_n, m_oe_n, m_oe, m_addr, m_dq},
                          {32'd0, 1'b1, 1'b1, 1'b1, 1'b0, 18'd0, 16'd0});
        chk("reset_rdata1", {32'd0, if1.read_data}, 64'd0);
        chk("reset_rdata0", {32'd0, if0.read_data}, 64'd0);
        @(posedge clk); #1;
        rst = 1'b0;

        // Directed table.
        for (int i = 0; i < 7; i++) begin
            run_txn(vecs[i].s, vecs[i].rd, vecs[i].wr, vecs[i].a, vecs[i].d,
                    vecs[i].ea, vecs[i].dlo, vecs[i].dhi, vecs[i].chk_rd, vecs[i].erd);
            if (!vecs[i].hold) idle_cycle();
        end
        repeat (3) @(posedge clk);
        @(negedge clk);
        sel = 1'b1;
        #1 chk("rd_hold_w1", {32'd0, m_rdata}, {32'd0, 32'hCAFEF00D});
        sel = 1'b0;
        #1 chk("rd_hold_w0", {32'd0, m_rdata}, {32'd0, 32'h0000AAAA});

        // Reset in the middle of a store (cycle 3 = first HIGH cycle with WAIT=1).
        txn_no++;
        $display("txn %0d inst=W1 store 0x11112222 to 1040 with reset at cycle 3", txn_no);
        @(posedge clk); #1;
        sel = 1'b1; rd_en = 1'b0; wr_en = 1'b1; address = 32'd1040; write_data = 32'h11112222;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1; wr_en = 1'b0;
        @(negedge clk);
        chk("mid_rst_still_wr", {63'd0, m_we_n}, 64'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("mid_rst_pins", {40'd0, m_ready, m_we_n, m_oe_n, m_oe, m_addr, 2'b00},
                            {40'd0, 1'b1, 1'b1, 1'b1, 1'b0, 18'd0, 2'b00});
        chk("mid_rst_rdata", {32'd0, m_rdata}, 64'd0);

        // Random traffic against the word-level reference.
        last_rd[0] = '0; last_rd[1] = '0;
        for (int s = 0; s < 2; s++)
            for (int w = 0; w < 256; w++) ref_ok[s][w] = 1'b0;
        for (int n = 0; n < 40; n++) begin
            bit          s, hold, do_rd, do_wr;
            int          idx;
            logic [31:0] a, d, erd;
            logic [17:0] ea;
            bit          crd;
            s     = 1'($urandom_range(0, 1));
            idx   = $urandom_range(100, 107);
            a     = 32'd1024 + 32'(idx) * 4 + 32'($urandom_range(0, 3));
            d     = $urandom;
            ea    = 18'(idx * 2);
            hold  = 1'($urandom_range(0, 1));
            do_rd = ref_ok[s][idx] && ($urandom_range(0, 2) != 0);
            do_wr = !do_rd;
            if (do_wr && $urandom_range(0, 4) == 0) do_rd = 1'b1;   // conflict: store wins
            crd = 1'b1;
            if (do_wr) begin
                ref_mem[s][idx] = d;
                ref_ok[s][idx]  = 1'b1;
                erd = last_rd[s];
            end else begin
                erd = ref_mem[s][idx];
                last_rd[s] = erd;
            end
            run_txn(s, do_rd, do_wr, a, d, ea, d[15:0], d[31:16], crd, erd);
            if (!hold) idle_cycle();
        end
        idle_cycle();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
